// File: rtl/alu_issue_queue_if.sv
// Request, arithmetic-unit and result channels of the ALU issue queue.
// No logic inside; pure signal bundle.
// Requests and results both use valid/ready handshakes.
interface alu_issue_queue_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [SEL_W-1:0] in_sel;
    logic             in_cin;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_result;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [SEL_W-1:0] res_sel;

    // Issue queue side
    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_cin, alu_result, res_ready,
        output in_ready, alu_a, alu_b, alu_sel, alu_cin, res_valid, res_data, res_sel
    );

    // Producer / consumer / arithmetic-unit side
    modport master (
        output in_valid, in_a, in_b, in_sel, in_cin, alu_result, res_ready,
        input  in_ready, alu_a, alu_b, alu_sel, alu_cin, res_valid, res_data, res_sel
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Buffers ALU requests in a FIFO and issues them one at a time to the arithmetic unit.
// Latency: push to result valid is LATENCY+2 edges when idle and empty.
// Backpressure: in_ready drops when the FIFO is full; a held result blocks further issue.
module alu_issue_queue #(
    parameter int WIDTH   = 8,
    parameter int SEL_W   = 4,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_issue_queue_if.slave       io,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESULT = 2'd2} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SEL_W-1:0] sel;
        logic             cin;
    } req_t;

    state_t           state_q, state_d;
    req_t             mem_q [DEPTH];
    req_t             mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       wcnt_q, wcnt_d;
    req_t             alu_q, alu_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [SEL_W-1:0] res_sel_q, res_sel_d;

    logic push;
    logic pop;
    logic has_entry;

    // No pop-through: readiness depends only on occupancy, so a full FIFO refuses
    // a push even on an edge that also pops.
    assign has_entry   = (cnt_q != '0);
    assign io.in_ready = rst_n && (cnt_q < CW'(DEPTH));
    assign push        = io.in_valid && io.in_ready;

    assign io.alu_a     = alu_q.a;
    assign io.alu_b     = alu_q.b;
    assign io.alu_sel   = alu_q.sel;
    assign io.alu_cin   = alu_q.cin;
    assign io.res_valid = res_valid_q;
    assign io.res_data  = res_data_q;
    assign io.res_sel   = res_sel_q;
    assign count        = cnt_q;

    // State register plus all datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            alu_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            alu_q       <= alu_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_sel_q   <= res_sel_d;
        end
    end

    // Next state; pop marks an issue edge (idle with work, or result accepted with work queued)
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (has_entry) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == '0) state_d = RESULT;
            end
            RESULT: begin
                if (io.res_ready) begin
                    if (has_entry) begin
                        pop     = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: issue registers, latency counter, result capture and busy flag
    always_comb begin
        alu_d       = alu_q;
        wcnt_d      = wcnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_sel_d   = res_sel_q;
        busy        = (state_q != IDLE) || has_entry;
        if (pop) begin
            alu_d  = mem_q[rd_ptr_q];
            wcnt_d = 4'(LATENCY);
        end else if (state_q == WAIT && wcnt_q != '0) begin
            wcnt_d = wcnt_q - 4'd1;
        end
        if (state_q == WAIT && wcnt_q == '0) begin
            res_valid_d = 1'b1;
            res_data_d  = io.alu_result;
            res_sel_d   = alu_q.sel;
        end else if (state_q == RESULT && io.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{a: io.in_a, b: io.in_b, sel: io.in_sel, cin: io.in_cin};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue with a registered and a combinational ALU model.
// A queue/timestamp model is compared every cycle; directed phases add literal checks.
// Consumer backpressure is exercised by holding or randomising res_ready.
module tb_alu_issue_queue;
    localparam int L = 1;
    localparam int D = 4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic       cin;
    } op_t;

    logic clk;
    logic rst_n;
    logic [2:0] count1, count0;
    logic busy1, busy0;

    alu_issue_queue_if #(.WIDTH(8), .SEL_W(4)) if1 ();
    alu_issue_queue_if #(.WIDTH(8), .SEL_W(4)) if0 ();

    alu_issue_queue #(.WIDTH(8), .SEL_W(4), .DEPTH(D), .LATENCY(L)) u_dut (
        .clk(clk), .rst_n(rst_n), .io(if1.slave), .count(count1), .busy(busy1)
    );
    alu_issue_queue #(.WIDTH(8), .SEL_W(4), .DEPTH(D), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .io(if0.slave), .count(count0), .busy(busy0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Arithmetic unit models: registered (LATENCY=1) and combinational (LATENCY=0)
    initial if1.alu_result = 8'd0;
    always @(posedge clk) if1.alu_result <= if1.alu_a + if1.alu_b + {7'd0, if1.alu_cin};
    assign if0.alu_result = if0.alu_a + if0.alu_b + {7'd0, if0.alu_cin};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Behavioural model: a request queue plus one in-flight op whose result becomes
    // visible a fixed number of edges after its issue edge.
    op_t m_q[$];
    op_t m_cur;
    op_t m_alu;
    bit  m_have;
    int  m_n;
    int  m_done;
    bit  m_valid, m_acc, m_push;
    op_t m_in;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_have = 1'b0;
            m_n    = 0;
            m_done = 0;
            m_alu  = '0;
            m_cur  = '0;
        end else begin
            m_valid = m_have && (m_n >= m_done);
            m_acc   = m_valid && (if1.res_ready === 1'b1);
            m_push  = (if1.in_valid === 1'b1) && (m_q.size() < D);
            m_in    = '{a: if1.in_a, b: if1.in_b, sel: if1.in_sel, cin: if1.in_cin};
            if ((!m_have || m_acc) && m_q.size() > 0) begin
                m_cur  = m_q.pop_front();
                m_alu  = m_cur;
                m_have = 1'b1;
                m_done = m_n + 1 + L + 1;
            end else if (m_acc) begin
                m_have = 1'b0;
            end
            if (m_push) m_q.push_back(m_in);
            m_n++;
        end
    end

    // Results the consumer actually accepted, as {sel, data}
    logic [11:0] got[$];
    int          max_cnt = 0;
    bit          acc_now;
    logic [7:0]  m_sum;
    bit          mv;

    // Per-cycle comparison against the model, shortly after each edge
    always @(posedge clk) begin
        acc_now = rst_n && (if1.res_valid === 1'b1) && (if1.res_ready === 1'b1);
        if (acc_now) got.push_back({if1.res_sel, if1.res_data});
        #1;
        if (rst_n) begin
            mv    = m_have && (m_n >= m_done);
            m_sum = m_cur.a + m_cur.b + {7'd0, m_cur.cin};
            if (32'(count1) > max_cnt) max_cnt = 32'(count1);
            chk("m_in_ready", 32'(if1.in_ready), 32'(m_q.size() < D));
            chk("m_count", 32'(count1), 32'(m_q.size()));
            chk("m_busy", 32'(busy1), 32'(m_have || m_q.size() > 0));
            chk("m_res_valid", 32'(if1.res_valid), 32'(mv));
            chk("m_alu_a", 32'(if1.alu_a), 32'(m_alu.a));
            chk("m_alu_b", 32'(if1.alu_b), 32'(m_alu.b));
            chk("m_alu_sel", 32'(if1.alu_sel), 32'(m_alu.sel));
            chk("m_alu_cin", 32'(if1.alu_cin), 32'(m_alu.cin));
            if (mv) begin
                chk("m_res_data", 32'(if1.res_data), 32'(m_sum));
                chk("m_res_sel", 32'(if1.res_sel), 32'(m_cur.sel));
            end
        end
    end

    // Present one request from a negedge and hold it until accepted
    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel, input logic cin);
        int t;
        if1.in_valid = 1'b1;
        if1.in_a     = a;
        if1.in_b     = b;
        if1.in_sel   = sel;
        if1.in_cin   = cin;
        t = 0;
        while (if1.in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeout("push_accept");
        @(negedge clk);
        if1.in_valid = 1'b0;
    endtask

    task automatic wait_res_valid(input string nm);
        int t;
        t = 0;
        while (if1.res_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout(nm);
    endtask

    task automatic drain(input string nm);
        int t;
        if1.res_ready = 1'b1;
        t = 0;
        while (busy1 !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) timeout(nm);
        if1.res_ready = 1'b0;
    endtask

    bit done;

    initial begin
        rst_n = 1'b0;
        if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.in_sel = '0; if1.in_cin = 1'b0;
        if1.res_ready = 1'b0;
        if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.in_sel = '0; if0.in_cin = 1'b0;
        if0.res_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(if1.in_ready), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_count", 32'(count1), 0);
        chk("rst_res_valid", 32'(if1.res_valid), 0);
        chk("rst_alu_a", 32'(if1.alu_a), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(if1.in_ready), 1);
        @(negedge clk);

        // Single op: 2+3+1 = 6
        push(8'd2, 8'd3, 4'd0, 1'b1);
        @(negedge clk);
        chk("single_alu_a", 32'(if1.alu_a), 2);
        chk("single_alu_b", 32'(if1.alu_b), 3);
        chk("single_valid_p1", 32'(if1.res_valid), 0);
        @(negedge clk);
        chk("single_valid_p2", 32'(if1.res_valid), 0);
        @(negedge clk);
        chk("single_valid_p3", 32'(if1.res_valid), 1);
        chk("single_data", 32'(if1.res_data), 6);
        chk("single_sel", 32'(if1.res_sel), 0);
        if1.res_ready = 1'b1;
        @(negedge clk);
        chk("single_busy_drop", 32'(busy1), 0);
        if1.res_ready = 1'b0;

        // Burst until full, last push stalls, then release the consumer
        got.delete();
        fork
            begin
                for (int s = 0; s < 6; s++) push(8'd2, 8'd3, 4'(s), 1'b1);
            end
            begin
                int t;
                t = 0;
                while (count1 !== 3'd4 && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 100) timeout("burst_fill");
                chk("full_in_ready", 32'(if1.in_ready), 0);
                repeat (3) @(negedge clk);
                chk("full_hold_valid", 32'(if1.res_valid), 1);
                chk("full_hold_data", 32'(if1.res_data), 6);
                chk("full_hold_sel", 32'(if1.res_sel), 0);
                chk("full_count", 32'(count1), 4);
                chk("full_stalled", 32'(if1.in_ready), 0);
                if1.res_ready = 1'b1;
            end
        join
        drain("burst_drain");
        chk("burst_n", 32'(got.size()), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            chk("burst_sel", 32'(got[i][11:8]), 32'(i));
            chk("burst_data", 32'(got[i][7:0]), 6);
        end

        // Backpressure: 7+9 = 16 held for 10 cycles, 1+1 = 2 queued behind it
        got.delete();
        push(8'd7, 8'd9, 4'd3, 1'b0);
        push(8'd1, 8'd1, 4'd4, 1'b0);
        wait_res_valid("bp_valid");
        for (int k = 0; k < 10; k++) begin
            chk("bp_data", 32'(if1.res_data), 16);
            chk("bp_sel", 32'(if1.res_sel), 3);
            chk("bp_alu_a", 32'(if1.alu_a), 7);
            chk("bp_alu_b", 32'(if1.alu_b), 9);
            chk("bp_count", 32'(count1), 1);
            @(negedge clk);
        end
        drain("bp_drain");
        chk("bp_n", 32'(got.size()), 2);
        if (got.size() == 2) begin
            chk("bp_first", 32'(got[0][7:0]), 16);
            chk("bp_second", 32'(got[1][7:0]), 2);
        end

        // Wrap with random producer gaps and random consumer readiness
        got.delete();
        max_cnt = 0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    push(8'(i), 8'd255, 4'(i), 1'b0);
                end
            end
            begin
                while (!done) begin
                    if1.res_ready = ($urandom_range(0, 1) == 1);
                    @(negedge clk);
                end
                if1.res_ready = 1'b0;
            end
            begin
                int t;
                t = 0;
                while (got.size() < 12 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 2000) timeout("wrap_results");
                done = 1'b1;
            end
        join
        drain("wrap_drain");
        chk("wrap_n", 32'(got.size()), 12);
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            chk("wrap_data", 32'(got[i][7:0]), 32'((i + 255) % 256));
            chk("wrap_sel", 32'(got[i][11:8]), 32'(i));
        end
        chk("wrap_max_count_le_4", 32'(max_cnt <= 4), 1);

        // Reset while an op is in WAIT with three entries queued
        got.delete();
        push(8'd5, 8'd5, 4'd1, 1'b0);
        wait_res_valid("rstw_first");
        for (int i = 1; i <= 4; i++) push(8'(i), 8'd1, 4'(i), 1'b0);
        chk("rstw_count_full", 32'(count1), 4);
        if1.res_ready = 1'b1;
        @(negedge clk);
        if1.res_ready = 1'b0;
        chk("rstw_count_3", 32'(count1), 3);
        chk("rstw_in_wait", 32'(if1.res_valid), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstw_in_ready", 32'(if1.in_ready), 0);
        chk("rstw_busy", 32'(busy1), 0);
        chk("rstw_count", 32'(count1), 0);
        chk("rstw_res_valid", 32'(if1.res_valid), 0);
        chk("rstw_res_data", 32'(if1.res_data), 0);
        chk("rstw_res_sel", 32'(if1.res_sel), 0);
        chk("rstw_alu_a", 32'(if1.alu_a), 0);
        chk("rstw_alu_b", 32'(if1.alu_b), 0);
        chk("rstw_alu_sel", 32'(if1.alu_sel), 0);
        chk("rstw_alu_cin", 32'(if1.alu_cin), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstw_rel_ready", 32'(if1.in_ready), 1);
        if1.res_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rstw_no_result", 32'(if1.res_valid), 0);
            chk("rstw_empty", 32'(count1), 0);
        end
        if1.res_ready = 1'b0;
        chk("rstw_delivered", 32'(got.size()), 1);
        if (got.size() == 1) chk("rstw_first_data", 32'(got[0][7:0]), 10);

        // Combinational unit: 200+100+1 = 301 mod 256 = 45, valid after P+2
        if0.in_valid = 1'b1;
        if0.in_a     = 8'd200;
        if0.in_b     = 8'd100;
        if0.in_sel   = 4'd2;
        if0.in_cin   = 1'b1;
        chk("l0_in_ready", 32'(if0.in_ready), 1);
        @(negedge clk);
        if0.in_valid = 1'b0;
        @(negedge clk);
        chk("l0_valid_p1", 32'(if0.res_valid), 0);
        chk("l0_alu_a", 32'(if0.alu_a), 200);
        @(negedge clk);
        chk("l0_valid_p2", 32'(if0.res_valid), 1);
        chk("l0_data", 32'(if0.res_data), 45);
        chk("l0_sel", 32'(if0.res_sel), 2);
        if0.res_ready = 1'b1;
        @(negedge clk);
        chk("l0_busy_drop", 32'(busy0), 0);
        if0.res_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
